event_fifo_arbiter: RTL and testbench
=====================================

// Module: event_fifo_arbiter
// PURPOSE
//  Shares one 64-bit event FIFO write port between N_SRC event_saver channels.
//  Each channel requests, receives a round-robin grant and streams one BURST_LEN-word frame.
//  The arbiter writes a header word in front of every frame and guards against FIFO overflow.
//  It also pads frames from stalled sources. Sits between the event_saver instances and the DAQ FIFO.
// PARAMETERS
//  N_SRC      4     number of requesting channels (2..8)
//  BURST_LEN  16    data words per frame (header excluded)
//  TIMEOUT    64    max idle cycles between granted words before padding
//  PAD_WORD   64'hDEAD_DEAD_DEAD_DEAD   filler for truncated frames
// PORTS
//  clk                 in   1            system clock
//  aresetn             in   1            async reset, active-low
//  req_i               in   N_SRC        level request per channel, held until frame sent
//  wr_en_i             in   N_SRC        per-channel word strobe
//  din_i               in   N_SRC x 64   per-channel data word
//  gnt_o               out  N_SRC        one-hot grant, high from HEADER through end of frame
//  fifo_full_i         in   1            FIFO full
//  fifo_almost_full_i  in   1            high when free slots < BURST_LEN+1
//  wr_en_o             out  1            FIFO write strobe (registered)
//  din_o               out  64           FIFO write data (registered)
//  busy_o              out  1            high in any state other than IDLE
//  seq_o               out  32           frames issued so far
//  overflow_o          out  1            sticky: a write was dropped on fifo_full_i
//  timeout_cnt_o       out  16           frames truncated by timeout, saturating
// BEHAVIOUR
//  Reset: async on aresetn=0.
//   - All outputs 0; state IDLE; rr pointer 0; seq 0.
//   - Reset mid-frame abandons the frame with no pad and no trailer.
//  FSM: IDLE -> HEADER -> STREAM -> (PAD) -> GAP -> IDLE.
//  IDLE:
//   - Entered when req_i != 0 and fifo_almost_full_i = 0.
//   - Winner = first set bit at or after rr_ptr, searching upward mod N_SRC.
//   - Winner is registered into gnt_o; next state HEADER.
//   - If fifo_almost_full_i = 1, stay in IDLE; requests stay pending.
//  HEADER (1 cycle):
//   - Next cycle wr_en_o = 1 and din_o = {8'hA5, 8'(src_id), 16'h0, seq}.
//   - seq then increments; it wraps 2^32-1 -> 0.
//  STREAM:
//   - A word is accepted when wr_en_i[src] = 1.
//   - Each accepted word appears on din_o/wr_en_o one cycle later.
//   - wr_en_i from non-granted channels is ignored.
//   - word_cnt counts accepted words; after word BURST_LEN go to GAP.
//   - idle_cnt resets on each accepted word. If idle_cnt reaches TIMEOUT, go to PAD.
//  PAD:
//   - Emit PAD_WORD one per cycle until word_cnt = BURST_LEN.
//   - Increment timeout_cnt_o once per truncated frame; it saturates at 16'hFFFF.
//   - Words the source sends late are ignored.
//   - Then go to GAP.
//  GAP (1 cycle):
//   - gnt_o = 0.
//   - rr_ptr = src+1 mod N_SRC, so the channel just served gets lowest priority.
//   - Next state IDLE.
//  Frame on FIFO: exactly 1 + BURST_LEN writes, always contiguous by source.
//  Overflow:
//   - If fifo_full_i = 1 in a cycle where wr_en_o would be 1, wr_en_o is forced to 0.
//   - The word is lost and overflow_o is set; it clears only on reset.
//   - The frame still counts as complete.
//  Simultaneous requests: resolved by rr_ptr only; no starvation.
//   - Worst-case wait = (N_SRC-1) x (BURST_LEN+3) cycles, if the FIFO never stays almost-full.
//  A req_i drop during STREAM is ignored; the frame completes or pads.
// TESTING
//  T1 single src: req_i=0001, 16 words, FIFO empty -> header A5_00_0000_00000000 then 16 words in order; gnt_o=0 after GAP; seq_o=1.
//  T2 contention: req_i=1111 held -> grants 0,1,2,3,0 in that order; headers carry seq 0..4; no interleaved words.
//  T3 backpressure: fifo_almost_full_i=1 while req_i=0010 -> no grant, busy_o=0; release -> grant within 2 cycles.
//  T4 stall: src 2 sends 5 words then stops -> after 64 idle cycles 11 x PAD_WORD; timeout_cnt_o=1; frame length 17.
//  T5 overflow: fifo_full_i=1 for 1 cycle during word 3 -> that word not written; overflow_o=1 until reset.
//  T6 reset mid-STREAM: aresetn=0 at word 8 -> all outputs 0 next edge; a new req after reset gets header with seq 0.

Source files
------------

// File: rtl/event_fifo_arbiter.sv
// event_fifo_arbiter
// Shares a single 64-bit event FIFO write port between N_SRC event_saver
// channels. A round-robin arbiter grants one channel at a time. Each granted
// frame goes out as one header word followed by exactly BURST_LEN data words.
// Sources that stall for TIMEOUT cycles have the rest of their frame filled
// with PAD_WORD. Writes that hit a full FIFO are dropped and flagged in a
// sticky overflow bit.

module event_fifo_arbiter #(
  parameter int          N_SRC     = 4,
  parameter int          BURST_LEN = 16,
  parameter int          TIMEOUT   = 64,
  parameter logic [63:0] PAD_WORD  = 64'hDEAD_DEAD_DEAD_DEAD
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [N_SRC-1:0]       req_i,
  input  logic [N_SRC-1:0]       wr_en_i,
  input  logic [N_SRC-1:0][63:0] din_i,
  output logic [N_SRC-1:0]       gnt_o,
  input  logic                   fifo_full_i,
  input  logic                   fifo_almost_full_i,
  output logic                   wr_en_o,
  output logic [63:0]            din_o,
  output logic                   busy_o,
  output logic [31:0]            seq_o,
  output logic                   overflow_o,
  output logic [15:0]            timeout_cnt_o
);

  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int WC_W  = $clog2(BURST_LEN + 1);
  localparam int IC_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_STREAM = 3'd2,
    S_PAD    = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  // Round-robin search: first set request at or after ptr, wrapping mod N_SRC.
  // Returns {found, index}.
  function automatic logic [SRC_W:0] rr_pick(input logic [N_SRC-1:0] req,
                                             input logic [SRC_W-1:0] ptr);
    logic             found;
    logic [SRC_W-1:0] idx;
    int               cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = (int'(ptr) + i) % N_SRC;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = SRC_W'(cand);
      end
    end
    return {found, idx};
  endfunction

  state_t           r_state;
  logic [SRC_W-1:0] r_src;
  logic [SRC_W-1:0] r_rr_ptr;
  logic [N_SRC-1:0] r_gnt;
  logic             r_busy;
  logic [31:0]      r_seq;
  logic [WC_W-1:0]  r_word_cnt;
  logic [IC_W-1:0]  r_idle_cnt;
  logic [15:0]      r_timeout_cnt;
  logic             r_wr_en;
  logic [63:0]      r_din;
  logic             r_overflow;

  logic [SRC_W:0]   w_pick;
  logic             w_win_vld;
  logic [SRC_W-1:0] w_win_idx;
  logic             w_acc;
  logic             w_last_word;
  logic             w_idle_exp;
  logic             w_push;
  logic [63:0]      w_word;

  assign w_pick      = rr_pick(req_i, r_rr_ptr);
  assign w_win_vld   = w_pick[SRC_W];
  assign w_win_idx   = w_pick[SRC_W-1:0];
  assign w_acc       = wr_en_i[r_src];
  assign w_last_word = (r_word_cnt == WC_W'(BURST_LEN - 1));
  assign w_idle_exp  = (r_idle_cnt == IC_W'(TIMEOUT - 1));

  // Select the word to be pushed to the FIFO this cycle, if any.
  always_comb begin
    w_push = 1'b0;
    w_word = r_din;
    case (r_state)
      S_HEADER: begin
        w_push = 1'b1;
        w_word = {8'hA5, 8'(r_src), 16'h0000, r_seq};
      end
      S_STREAM: begin
        if (w_acc) begin
          w_push = 1'b1;
          w_word = din_i[r_src];
        end else begin
          w_push = 1'b0;
          w_word = r_din;
        end
      end
      S_PAD: begin
        w_push = 1'b1;
        w_word = PAD_WORD;
      end
      default: begin
        w_push = 1'b0;
        w_word = r_din;
      end
    endcase
  end

  // FIFO write port: register the pushed word, drop it when the FIFO is full.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_en    <= 1'b0;
      r_din      <= 64'h0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_en <= w_push & ~fifo_full_i;
      if (w_push && !fifo_full_i) begin
        r_din <= w_word;
      end
      if (w_push && fifo_full_i) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Arbitration and framing FSM with registered grant, busy and counters.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_src         <= '0;
      r_rr_ptr      <= '0;
      r_gnt         <= '0;
      r_busy        <= 1'b0;
      r_seq         <= 32'h0;
      r_word_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_timeout_cnt <= 16'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Hold off new frames while the FIFO cannot absorb a full one.
          if (w_win_vld && !fifo_almost_full_i) begin
            r_src      <= w_win_idx;
            r_gnt      <= {{(N_SRC-1){1'b0}}, 1'b1} << w_win_idx;
            r_busy     <= 1'b1;
            r_word_cnt <= '0;
            r_idle_cnt <= '0;
            r_state    <= S_HEADER;
          end
        end
        S_HEADER: begin
          r_seq   <= r_seq + 32'd1;
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_acc) begin
            r_idle_cnt <= '0;
            r_word_cnt <= r_word_cnt + WC_W'(1);
            if (w_last_word) begin
              r_gnt   <= '0;
              r_state <= S_GAP;
            end
          end else if (w_idle_exp) begin
            // Source stalled too long: fill the rest of the frame.
            r_idle_cnt <= '0;
            r_state    <= S_PAD;
            if (r_timeout_cnt != 16'hFFFF) begin
              r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end
          end else begin
            r_idle_cnt <= r_idle_cnt + IC_W'(1);
          end
        end
        S_PAD: begin
          r_word_cnt <= r_word_cnt + WC_W'(1);
          if (w_last_word) begin
            r_gnt   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          // Channel just served drops to lowest priority.
          r_rr_ptr <= (r_src == SRC_W'(N_SRC - 1)) ? '0 : r_src + SRC_W'(1);
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o         = r_gnt;
  assign wr_en_o       = r_wr_en;
  assign din_o         = r_din;
  assign busy_o        = r_busy;
  assign seq_o         = r_seq;
  assign overflow_o    = r_overflow;
  assign timeout_cnt_o = r_timeout_cnt;

endmodule

// File: tb/tb_event_fifo_arbiter.sv
// Directed testbench for event_fifo_arbiter (N_SRC=4, BURST_LEN=16, TIMEOUT=64).
`timescale 1ns/1ps

module tb_event_fifo_arbiter;

  localparam int          N    = 4;
  localparam logic [63:0] PADW = 64'hDEAD_DEAD_DEAD_DEAD;

  logic             clk = 1'b0;
  logic             aresetn;
  logic [N-1:0]     req_i;
  logic [N-1:0]     wr_en_i;
  logic [N-1:0][63:0] din_i;
  logic [N-1:0]     gnt_o;
  logic             fifo_full_i;
  logic             fifo_almost_full_i;
  logic             wr_en_o;
  logic [63:0]      din_o;
  logic             busy_o;
  logic [31:0]      seq_o;
  logic             overflow_o;
  logic [15:0]      timeout_cnt_o;

  int checks   = 0;
  int failures = 0;

  logic [63:0] cap[$];

  always #5 clk = ~clk;

  event_fifo_arbiter #(
    .N_SRC(4), .BURST_LEN(16), .TIMEOUT(64), .PAD_WORD(PADW)
  ) dut (
    .clk(clk), .aresetn(aresetn), .req_i(req_i), .wr_en_i(wr_en_i),
    .din_i(din_i), .gnt_o(gnt_o), .fifo_full_i(fifo_full_i),
    .fifo_almost_full_i(fifo_almost_full_i), .wr_en_o(wr_en_o),
    .din_o(din_o), .busy_o(busy_o), .seq_o(seq_o), .overflow_o(overflow_o),
    .timeout_cnt_o(timeout_cnt_o)
  );

  // Record every FIFO write seen on the output port.
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) cap.push_back(din_o);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pat(input int s, input int k);
    return {8'h5A, 8'(s), 16'hBEEF, 32'(k + 256)};
  endfunction

  function automatic logic [63:0] hdr(input int s, input int sq);
    return {8'hA5, 8'(s), 16'h0000, 32'(sq)};
  endfunction

  function automatic logic [63:0] cap_at(input int i);
    if (i < cap.size()) return cap[i];
    else return 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    req_i = '0; wr_en_i = '0; din_i = '0;
    fifo_full_i = 1'b0; fifo_almost_full_i = 1'b0;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    cap.delete();
    @(negedge clk);
  endtask

  // Wait (bounded) for any grant, then check it is the expected one-hot.
  task automatic wait_grant(input int src, input int bound);
    int n = 0;
    while (gnt_o == '0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("gnt_src%0d", src), 64'(gnt_o), 64'(4'b0001 << src));
    chk("busy_in_frame", 64'(busy_o), 64'd1);
  endtask

  // Called in the HEADER cycle; streams n words starting in STREAM.
  task automatic stream_words(input int src, input int n, input bit noise, input int full_at);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < N; j++) din_i[j] = pat(j, k);
      wr_en_i     = noise ? 4'b1111 : (4'b0001 << src);
      fifo_full_i = (k == full_at);
      @(negedge clk);
    end
    wr_en_i     = '0;
    fifo_full_i = 1'b0;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};

    // Reset state
    aresetn = 1'b0;
    req_i = '0; wr_en_i = '0; din_i = '0;
    fifo_full_i = 1'b0; fifo_almost_full_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_wr_en", 64'(wr_en_o), 64'd0);
    chk("rst_din", din_o, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_seq", 64'(seq_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_tmo", 64'(timeout_cnt_o), 64'd0);
    aresetn = 1'b1;
    @(negedge clk);

    // T1: single source, full frame
    req_i = 4'b0001;
    wait_grant(0, 10);
    chk("t1_no_write_in_header", 64'(wr_en_o), 64'd0);
    stream_words(0, 16, 1'b0, -1);
    req_i = '0;
    repeat (4) @(negedge clk);
    chk("t1_len", 64'(cap.size()), 64'd17);
    chk("t1_hdr", cap_at(0), 64'hA500_0000_0000_0000);
    for (int k = 0; k < 16; k++) chk($sformatf("t1_w%0d", k), cap_at(1 + k), pat(0, k));
    chk("t1_gnt_after", 64'(gnt_o), 64'd0);
    chk("t1_busy_after", 64'(busy_o), 64'd0);
    chk("t1_seq", 64'(seq_o), 64'd1);

    // T2: contention, other channels strobe too and must be ignored
    do_reset();
    req_i = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_grant(order[f], 60);
      stream_words(order[f], 16, 1'b1, -1);
    end
    req_i = '0;
    repeat (4) @(negedge clk);
    chk("t2_len", 64'(cap.size()), 64'd85);
    for (int f = 0; f < 5; f++) begin
      chk($sformatf("t2_hdr%0d", f), cap_at(17 * f), hdr(order[f], f));
      for (int k = 0; k < 16; k++)
        chk($sformatf("t2_f%0d_w%0d", f, k), cap_at(17 * f + 1 + k), pat(order[f], k));
    end
    chk("t2_seq", 64'(seq_o), 64'd5);

    // T3: almost-full backpressure
    do_reset();
    fifo_almost_full_i = 1'b1;
    req_i = 4'b0010;
    repeat (10) @(negedge clk);
    chk("t3_gnt_held", 64'(gnt_o), 64'd0);
    chk("t3_busy_held", 64'(busy_o), 64'd0);
    fifo_almost_full_i = 1'b0;
    wait_grant(1, 2);
    stream_words(1, 16, 1'b0, -1);
    req_i = '0;
    repeat (4) @(negedge clk);
    chk("t3_len", 64'(cap.size()), 64'd17);
    chk("t3_hdr", cap_at(0), hdr(1, 0));

    // T4: stall after 5 words, timeout padding
    do_reset();
    req_i = 4'b0100;
    wait_grant(2, 10);
    stream_words(2, 5, 1'b0, -1);
    req_i = '0;
    repeat (63) @(negedge clk);
    chk("t4_tmo_before", 64'(timeout_cnt_o), 64'd0);
    @(negedge clk);
    chk("t4_tmo_at", 64'(timeout_cnt_o), 64'd1);
    @(negedge clk);
    wr_en_i[2] = 1'b1;
    din_i[2]   = 64'h0000_0000_0000_1234;
    @(negedge clk);
    wr_en_i = '0;
    repeat (20) @(negedge clk);
    chk("t4_len", 64'(cap.size()), 64'd17);
    chk("t4_hdr", cap_at(0), hdr(2, 0));
    for (int k = 0; k < 5; k++) chk($sformatf("t4_w%0d", k), cap_at(1 + k), pat(2, k));
    for (int k = 5; k < 16; k++) chk($sformatf("t4_pad%0d", k), cap_at(1 + k), PADW);
    chk("t4_tmo", 64'(timeout_cnt_o), 64'd1);
    chk("t4_gnt_after", 64'(gnt_o), 64'd0);
    chk("t4_busy_after", 64'(busy_o), 64'd0);

    // T5: FIFO full during word 3
    do_reset();
    req_i = 4'b0001;
    wait_grant(0, 10);
    chk("t5_ovf_before", 64'(overflow_o), 64'd0);
    stream_words(0, 16, 1'b0, 3);
    req_i = '0;
    repeat (10) @(negedge clk);
    chk("t5_len", 64'(cap.size()), 64'd16);
    chk("t5_hdr", cap_at(0), hdr(0, 0));
    for (int k = 0; k < 3; k++) chk($sformatf("t5_w%0d", k), cap_at(1 + k), pat(0, k));
    for (int k = 4; k < 16; k++) chk($sformatf("t5_w%0d", k), cap_at(k), pat(0, k));
    chk("t5_ovf", 64'(overflow_o), 64'd1);
    chk("t5_seq", 64'(seq_o), 64'd1);

    // T6: reset in the middle of a stream
    do_reset();
    req_i = 4'b0001;
    wait_grant(0, 10);
    stream_words(0, 8, 1'b0, -1);
    aresetn = 1'b0;
    #1;
    chk("t6_gnt", 64'(gnt_o), 64'd0);
    chk("t6_wr_en", 64'(wr_en_o), 64'd0);
    chk("t6_din", din_o, 64'd0);
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_seq", 64'(seq_o), 64'd0);
    chk("t6_ovf", 64'(overflow_o), 64'd0);
    chk("t6_tmo", 64'(timeout_cnt_o), 64'd0);
    do_reset();
    req_i = 4'b0001;
    wait_grant(0, 10);
    stream_words(0, 16, 1'b0, -1);
    req_i = '0;
    repeat (4) @(negedge clk);
    chk("t6_len", 64'(cap.size()), 64'd17);
    chk("t6_hdr", cap_at(0), 64'hA500_0000_0000_0000);
    chk("t6_seq_after", 64'(seq_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
